// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//
// Instruction-fetch front end. It owns the fetch PC, a synchronous-read
// instruction memory and a FIFO of fetched {pc, inst} pairs, which it hands
// to decode over a valid/ready handshake. A redirect flushes everything in
// flight and restarts fetch at the target address.
//
// Parameters
//   XLEN        PC and instruction width
//   RESET_PC    first fetch address after reset
//   IMEM_DEPTH  instruction memory words (power of two)
//   FQ_DEPTH    fetch queue entries (power of two, >= 2)
//
// Ports
//   clk               clock; all state updates on the rising edge
//   rst               synchronous active-high reset
//   redirect_valid_i  flush and restart fetch at redirect_pc_i
//   redirect_pc_i     redirect target (bits [1:0] forced to zero)
//   out_valid_o       queue head holds a valid instruction
//   out_ready_i       decode accepts the head this cycle
//   out_pc_o          PC of the head entry
//   out_inst_o        instruction word of the head entry
//   fq_count_o        registered queue occupancy
//
// instruction_memory has no write port; it is loaded by hierarchical access.
module if_fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_DEPTH = 1024,
  parameter int unsigned     FQ_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid_i,
  input  logic [XLEN-1:0]           redirect_pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [XLEN-1:0]           out_pc_o,
  output logic [XLEN-1:0]           out_inst_o,
  output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam logic [PW:0] FQ_FULL = (PW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] instruction_memory [IMEM_DEPTH];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] resp_pc_q;
  logic [XLEN-1:0] resp_inst_q;

  logic [XLEN-1:0] fq_pc_q   [FQ_DEPTH];
  logic [XLEN-1:0] fq_inst_q [FQ_DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;

  logic            deq;
  logic            push;
  logic            issue;
  logic [PW:0]     credit;

  assign out_valid_o = (count_q != '0);
  assign fq_count_o  = count_q;
  assign out_pc_o    = out_valid_o ? fq_pc_q[head_q]   : '0;
  assign out_inst_o  = out_valid_o ? fq_inst_q[head_q] : '0;

  always_comb begin
    deq    = out_valid_o & out_ready_i;
    // A response arriving in a redirect cycle belongs to the old stream.
    push   = inflight_q & ~redirect_valid_i;
    // Credit counts queued entries plus the read still in flight, so the
    // queue can never be oversubscribed; a same-cycle dequeue frees a slot.
    credit = count_q + {{PW{1'b0}}, inflight_q} - {{PW{1'b0}}, deq};
    issue  = ~redirect_valid_i & (credit < FQ_FULL);

    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)  tail_d     = tail_q + PW'(1);
      if (deq)   head_d     = head_q + PW'(1);
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, deq};
    end
  end

  // Issue stage: synchronous memory read, tagged with the PC it came from.
  always_ff @(posedge clk) begin
    if (issue) begin
      resp_pc_q   <= fetch_pc_q;
      resp_inst_q <= instruction_memory[fetch_pc_q[2 +: AW]];
    end
  end

  // Response / queue stage: control state and queue storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]   <= '0;
        fq_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        fq_pc_q[tail_q]   <= resp_pc_q;
        fq_inst_q[tail_q] <= resp_inst_q;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      fq_no_overflow: assert (!(push && !deq && (count_q == FQ_FULL)));
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_cnt;

  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [2:0]  w_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .IMEM_DEPTH(1024), .FQ_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (ready),
    .out_pc_o         (out_pc),
    .out_inst_o       (out_inst),
    .fq_count_o       (out_cnt)
  );

  // Small memory instance used for the address wrap-around case.
  if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .IMEM_DEPTH(16), .FQ_DEPTH(4)) dut_w (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (w_valid),
    .out_ready_i      (ready),
    .out_pc_o         (w_pc),
    .out_inst_o       (w_inst),
    .fq_count_o       (w_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"},    out_pc,   pc);
    check({tag, "_inst"},  out_inst, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ready          = 1'b0;
    for (int i = 0; i < 1024; i++) dut.instruction_memory[i] = 32'(i);
    dut.instruction_memory[1023] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) dut_w.instruction_memory[i] = 32'h100 + 32'(i);

    step(); step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, out_cnt}, 32'd0);
    check("rst_pc",    out_pc, 32'd0);
    check("rst_inst",  out_inst, 32'd0);

    // Sequential fetch with ready held high.
    rst = 1'b0; ready = 1'b1;            // cycle 0
    check("seq_c0_valid", {31'd0, out_valid}, 32'd0);
    step();                              // cycle 1
    check("seq_c1_valid", {31'd0, out_valid}, 32'd0);
    step();                              // cycle 2
    check_head("seq0", 32'h0, 32'd0);
    check("seq0_count", {29'd0, out_cnt}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      step();
      check_head($sformatf("seq%0d", i), 32'(4 * i), 32'(i));
      check($sformatf("seq%0d_count", i), {29'd0, out_cnt}, 32'd1);
    end

    // Build up occupancy, then reset mid-operation.
    ready = 1'b0;
    step();
    check("half_count", {29'd0, out_cnt}, 32'd2);
    check_head("half_hold", 32'h3C, 32'd15);
    rst = 1'b1;
    step();
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_count", {29'd0, out_cnt}, 32'd0);
    check("mrst_pc",    out_pc, 32'd0);
    check("mrst_inst",  out_inst, 32'd0);

    // Backpressure for cycles 0..9 after reset.
    rst = 1'b0;                          // cycle 0
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      check($sformatf("bp_c%0d_count", c), {29'd0, out_cnt},
            (c < 2) ? 32'd0 : ((c > 5) ? 32'd4 : 32'(c - 1)));
      check($sformatf("bp_c%0d_valid", c), {31'd0, out_valid}, (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        check($sformatf("bp_c%0d_pc", c),   out_pc,   32'h0);
        check($sformatf("bp_c%0d_inst", c), out_inst, 32'd0);
      end
    end
    check("bp_fetch_pc_hold", dut.fetch_pc_q, 32'h10);
    step();                              // cycle 10
    ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      check_head($sformatf("bp_drain%0d", k), 32'(4 * k), 32'(k));
    end

    // Redirect with a simultaneous dequeue and a read in flight.
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b1;            // cycle 0
    step(); step(); step(); step();      // cycle 4
    check_head("rd_pre", 32'h8, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();                              // cycle 5
    redirect_valid = 1'b0;
    check("rd_r1_valid", {31'd0, out_valid}, 32'd0);
    check("rd_r1_count", {29'd0, out_cnt}, 32'd0);
    step();                              // cycle 6
    check("rd_r2_valid", {31'd0, out_valid}, 32'd0);
    check("rd_r2_count", {29'd0, out_cnt}, 32'd0);
    step();                              // cycle 7
    check_head("rd_tgt0", 32'h40, 32'd16);
    step();                              // cycle 8
    check_head("rd_tgt1", 32'h44, 32'd17);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();                              // cycle 9
    check("b2b_r1_valid", {31'd0, out_valid}, 32'd0);
    redirect_pc = 32'h44;
    step();                              // cycle 10
    redirect_valid = 1'b0;
    check("b2b_r2_valid", {31'd0, out_valid}, 32'd0);
    step();                              // cycle 11
    check("b2b_r3_valid", {31'd0, out_valid}, 32'd0);
    step();                              // cycle 12
    check_head("b2b_tgt0", 32'h44, 32'd17);
    step();                              // cycle 13
    check_head("b2b_tgt1", 32'h48, 32'd18);

    // Memory index wrap-around (16-word instance) at pc 0x3C -> 0x40.
    redirect_valid = 1'b1; redirect_pc = 32'h3C;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check_head("wrap_big0", 32'h3C, 32'd15);
    check("wrap_w0_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_w0_pc",    w_pc,   32'h3C);
    check("wrap_w0_inst",  w_inst, 32'h10F);
    step();
    check_head("wrap_big1", 32'h40, 32'd16);
    check("wrap_w1_pc",    w_pc,   32'h40);
    check("wrap_w1_inst",  w_inst, 32'h100);

    // PC wrap modulo 2^32, with low target bits ignored.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check_head("pcwrap0", 32'hFFFF_FFFC, 32'hDEAD_BEEF);
    step();
    check_head("pcwrap1", 32'h0, 32'd0);
    step();
    check_head("pcwrap2", 32'h4, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
